// File: rtl/seg_scan_driver_if.sv
// Frame-load and display-pin bundle for seg_scan_driver.
// The master is the application side; the slave is the scan driver.
interface seg_scan_driver_if #(
  parameter int unsigned DIGITS = 6
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [DIGITS-1:0]     seg_sel;
  logic [7:0]            seg_data;
  logic                  frame_start;

  modport master (
    output load, data_in, dp_in, blank_in,
    input  seg_sel, seg_data, frame_start
  );

  modport slave (
    input  load, data_in, dp_in, blank_in,
    output seg_sel, seg_data, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with dead time and tear-free frame updates.
// Optional macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_driver #(
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned SCAN_DIV    = 2500,
  parameter int unsigned DEAD_CYCLES = 50
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_driver_if.slave  bus
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_LIM = DIV_W'(DEAD_CYCLES);

  logic [DIV_W-1:0]      r_div;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_pending;
  logic [4*DIGITS-1:0]   r_sh_data;
  logic [DIGITS-1:0]     r_sh_dp;
  logic [DIGITS-1:0]     r_sh_blank;
  logic [4*DIGITS-1:0]   r_act_data;
  logic [DIGITS-1:0]     r_act_dp;
  logic [DIGITS-1:0]     r_act_blank;
  logic [DIGITS-1:0]     r_seg_sel;
  logic [7:0]            r_seg_data;
  logic                  r_frame_start;

  logic                  w_slot_end;
  logic                  w_frame_wrap;
  logic [DIV_W-1:0]      w_div_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_pending_nxt;
  logic [4*DIGITS-1:0]   w_act_data_nxt;
  logic [DIGITS-1:0]     w_act_dp_nxt;
  logic [DIGITS-1:0]     w_act_blank_nxt;
  logic [DIGITS-1:0]     w_lz;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic                  w_blank;
  logic [7:0]            w_font;
  logic [DIGITS-1:0]     w_sel_nxt;
  logic [7:0]            w_data_nxt;

  always_comb begin
    w_slot_end      = (r_div == DIV_LAST);
    w_frame_wrap    = w_slot_end && (r_idx == IDX_LAST);
    w_div_nxt       = w_slot_end ? '0 : r_div + 1'b1;
    w_idx_nxt       = r_idx;
    w_pending_nxt   = r_pending;
    w_act_data_nxt  = r_act_data;
    w_act_dp_nxt    = r_act_dp;
    w_act_blank_nxt = r_act_blank;
    if (w_slot_end) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
    // A load on the wrap cycle bypasses the shadow so it is never held a frame.
    if (w_frame_wrap) begin
      w_pending_nxt = 1'b0;
      if (bus.load) begin
        w_act_data_nxt  = bus.data_in;
        w_act_dp_nxt    = bus.dp_in;
        w_act_blank_nxt = bus.blank_in;
      end else if (r_pending) begin
        w_act_data_nxt  = r_sh_data;
        w_act_dp_nxt    = r_sh_dp;
        w_act_blank_nxt = r_sh_blank;
      end
    end else if (bus.load) begin
      w_pending_nxt = 1'b1;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic w_run;

  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      w_run = w_run && (w_act_data_nxt[4*i +: 4] == 4'h0) && !w_act_dp_nxt[i];
      w_lz[i] = w_run;
    end
  end
`else
  assign w_lz = '0;
`endif

  // Outputs are decoded from next state so they line up with div/idx after the edge.
  always_comb begin
    w_nib     = 4'h0;
    w_dp      = 1'b0;
    w_blank   = 1'b1;
    w_sel_nxt = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nib        = w_act_data_nxt[4*i +: 4];
        w_dp         = w_act_dp_nxt[i];
        w_blank      = w_act_blank_nxt[i] | w_lz[i];
        w_sel_nxt[i] = 1'b0;
      end
    end
    if (w_div_nxt < DEAD_LIM) begin
      w_sel_nxt = '1;
    end
    case (w_nib)
      4'h0: w_font = 8'hC0;
      4'h1: w_font = 8'hF9;
      4'h2: w_font = 8'hA4;
      4'h3: w_font = 8'hB0;
      4'h4: w_font = 8'h99;
      4'h5: w_font = 8'h92;
      4'h6: w_font = 8'h82;
      4'h7: w_font = 8'hF8;
      4'h8: w_font = 8'h80;
      4'h9: w_font = 8'h90;
      4'hA: w_font = 8'h88;
      4'hB: w_font = 8'h83;
      4'hC: w_font = 8'hC6;
      4'hD: w_font = 8'hA1;
      4'hE: w_font = 8'h86;
      default: w_font = 8'h8E;
    endcase
    if (w_blank) begin
      w_data_nxt = 8'hFF;
    end else if (w_dp) begin
      w_data_nxt = w_font & 8'h7F;
    end else begin
      w_data_nxt = w_font;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_idx         <= '0;
      r_pending     <= 1'b0;
      r_sh_data     <= '0;
      r_sh_dp       <= '0;
      r_sh_blank    <= '1;
      r_act_data    <= '0;
      r_act_dp      <= '0;
      r_act_blank   <= '1;
      r_seg_sel     <= '1;
      r_seg_data    <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_idx         <= w_idx_nxt;
      r_pending     <= w_pending_nxt;
      r_act_data    <= w_act_data_nxt;
      r_act_dp      <= w_act_dp_nxt;
      r_act_blank   <= w_act_blank_nxt;
      r_seg_sel     <= w_sel_nxt;
      r_seg_data    <= w_data_nxt;
      r_frame_start <= w_frame_wrap;
      if (bus.load) begin
        r_sh_data  <= bus.data_in;
        r_sh_dp    <= bus.dp_in;
        r_sh_blank <= bus.blank_in;
      end
    end
  end

  assign bus.seg_sel     = r_seg_sel;
  assign bus.seg_data    = r_seg_data;
  assign bus.frame_start = r_frame_start;

endmodule
